ysyx_25040118_wbu: RTL and testbench

Write-back unit for the multi-cycle RV32E NPC, sitting directly upstream of the general-purpose register file. It accepts one retiring instruction at a time from the execute stage. For loads, it waits on the data-memory read response, then aligns and sign- or zero-extends the data. It drives a single-cycle write pulse into the register file and signals instruction completion to the fetch stage.

---
 rtl/ysyx_25040118_wbu_if.sv | 29 ++
 rtl/ysyx_25040118_wbu.sv | 100 ++++++++++
 tb/tb_ysyx_25040118_wbu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ysyx_25040118_wbu_if.sv
// ysyx_25040118_wbu_if: execute/memory/register-file bundle around the write-back unit
interface ysyx_25040118_wbu_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_rd_wen;
   logic [31:0] in_result;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic        rresp_valid;
   logic [31:0] rresp_data;
   logic        rresp_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        rf_wen;
   logic        wb_done;
   logic        wb_err;
   logic [31:0] commit_cnt;
   modport master (
      output in_valid, in_rd, in_rd_wen, in_result, in_is_load, in_funct3,
             rresp_valid, rresp_data, rresp_err,
      input  in_ready, rf_waddr, rf_wdata, rf_wen, wb_done, wb_err, commit_cnt
   );
   modport slave (
      input  in_valid, in_rd, in_rd_wen, in_result, in_is_load, in_funct3,
             rresp_valid, rresp_data, rresp_err,
      output in_ready, rf_waddr, rf_wdata, rf_wen, wb_done, wb_err, commit_cnt
   );
endinterface

// File: rtl/ysyx_25040118_wbu.sv
// ysyx_25040118_wbu: write-back unit, load alignment/extension and register-file write pulse
module ysyx_25040118_wbu #(
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst,
   ysyx_25040118_wbu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [4:0]    rd_q;
   logic [2:0]    f3_q;
   logic [1:0]    a_q;
   logic          wen_q;
   logic [31:0]   sh;
   logic [31:0]   ld_data;
   logic [15:0]   h;
   logic          f3_ok;
   logic          mis;
   logic          acc_wen;
   assign bus.in_ready = state == IDLE;
   // decode of the incoming instruction and extraction of the load response
   always_comb begin
      sh      = bus.rresp_data >> {a_q, 3'b000};
      h       = a_q[1] ? bus.rresp_data[31:16] : bus.rresp_data[15:0];
      ld_data = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & h[15]}}, h} : bus.rresp_data;
      f3_ok   = bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      mis     = (bus.in_funct3[1:0] == 2'b01 && bus.in_result[0]) ||
                (bus.in_funct3 == 3'b010 && bus.in_result[1:0] != 2'b00);
      acc_wen = bus.in_rd_wen && bus.in_rd != 5'd0 && !bus.in_rd[4];
   end
   // FSM; the write pulse, done pulse and counter are loaded on entry to COMMIT so they are visible during it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= '0;
         rd_q           <= '0;
         f3_q           <= '0;
         a_q            <= '0;
         wen_q          <= 1'b0;
         bus.rf_waddr   <= '0;
         bus.rf_wdata   <= '0;
         bus.rf_wen     <= 1'b0;
         bus.wb_done    <= 1'b0;
         bus.wb_err     <= 1'b0;
         bus.commit_cnt <= '0;
      end else begin
         bus.rf_wen  <= 1'b0;
         bus.wb_done <= 1'b0;
         case (state)
            IDLE: if (bus.in_valid) begin
               rd_q <= bus.in_rd;
               f3_q <= bus.in_funct3;
               a_q  <= bus.in_result[1:0];
               cnt  <= '0;
               if (bus.in_rd_wen && bus.in_rd[4]) bus.wb_err <= 1'b1;
               if (!bus.in_is_load) begin
                  state          <= COMMIT;
                  bus.rf_wen     <= acc_wen;
                  bus.wb_done    <= 1'b1;
                  bus.rf_waddr   <= bus.in_rd;
                  bus.rf_wdata   <= bus.in_result;
                  bus.commit_cnt <= bus.commit_cnt + 32'd1;
               end else if (!f3_ok || mis) begin
                  state          <= COMMIT;
                  bus.wb_err     <= 1'b1;
                  bus.wb_done    <= 1'b1;
                  bus.rf_waddr   <= bus.in_rd;
                  bus.commit_cnt <= bus.commit_cnt + 32'd1;
               end else begin
                  wen_q <= acc_wen;
                  state <= WAIT_MEM;
               end
            end
            WAIT_MEM: begin
               cnt <= cnt + 1'b1;
               if (bus.rresp_valid) begin
                  state          <= COMMIT;
                  bus.rf_wen     <= wen_q && !bus.rresp_err;
                  bus.wb_done    <= 1'b1;
                  bus.rf_waddr   <= rd_q;
                  bus.rf_wdata   <= ld_data;
                  bus.commit_cnt <= bus.commit_cnt + 32'd1;
                  if (bus.rresp_err) bus.wb_err <= 1'b1;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state          <= COMMIT;
                  bus.wb_err     <= 1'b1;
                  bus.wb_done    <= 1'b1;
                  bus.rf_waddr   <= rd_q;
                  bus.commit_cnt <= bus.commit_cnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_25040118_wbu.sv
// tb_ysyx_25040118_wbu: directed vectors for the write-back unit
module tb_ysyx_25040118_wbu;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   ysyx_25040118_wbu_if bus();
   ysyx_25040118_wbu #(.TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      bus.in_valid    = 1'b0;
      bus.in_rd       = '0;
      bus.in_rd_wen   = 1'b0;
      bus.in_result   = '0;
      bus.in_is_load  = 1'b0;
      bus.in_funct3   = '0;
      bus.rresp_valid = 1'b0;
      bus.rresp_data  = '0;
      bus.rresp_err   = 1'b0;
   endtask
   task automatic do_reset;
      rst = 1'b0;
      idle_in();
      step();
      step();
      rst = 1'b1;
   endtask
   task automatic issue(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                        input logic ld, input logic [2:0] f3);
      bus.in_valid   = 1'b1;
      bus.in_rd      = rd;
      bus.in_rd_wen  = wen;
      bus.in_result  = res;
      bus.in_is_load = ld;
      bus.in_funct3  = f3;
      step();
      bus.in_valid   = 1'b0;
   endtask
   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic err, input int dly, input logic [31:0] exp_data,
                       input logic exp_wen, input logic exp_err);
      issue(5'd3, 1'b1, addr, 1'b1, f3);
      chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      repeat (dly) step();
      bus.rresp_valid = 1'b1;
      bus.rresp_data  = 32'h80FF7F01;
      bus.rresp_err   = err;
      step();
      bus.rresp_valid = 1'b0;
      bus.rresp_err   = 1'b0;
      chk({tag, "_done"}, 32'(bus.wb_done), 32'd1);
      chk({tag, "_wen"}, 32'(bus.rf_wen), 32'(exp_wen));
      chk({tag, "_err"}, 32'(bus.wb_err), 32'(exp_err));
      if (exp_wen) chk({tag, "_data"}, bus.rf_wdata, exp_data);
      step();
   endtask
   initial begin
      do_reset();
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
      chk("rst_wdata", bus.rf_wdata, 32'd0);
      chk("rst_wen", 32'(bus.rf_wen), 32'd0);
      chk("rst_done", 32'(bus.wb_done), 32'd0);
      chk("rst_err", 32'(bus.wb_err), 32'd0);
      chk("rst_cnt", bus.commit_cnt, 32'd0);
      issue(5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 3'b000);
      chk("alu_wen", 32'(bus.rf_wen), 32'd1);
      chk("alu_waddr", 32'(bus.rf_waddr), 32'd5);
      chk("alu_wdata", bus.rf_wdata, 32'hDEADBEEF);
      chk("alu_done", 32'(bus.wb_done), 32'd1);
      chk("alu_cnt", bus.commit_cnt, 32'd1);
      chk("alu_busy", 32'(bus.in_ready), 32'd0);
      step();
      chk("alu_ready", 32'(bus.in_ready), 32'd1);
      chk("alu_wen_off", 32'(bus.rf_wen), 32'd0);
      chk("alu_hold", bus.rf_wdata, 32'hDEADBEEF);
      load("lb", 3'b000, 32'h80000002, 1'b0, 0, 32'hFFFFFFFF, 1'b1, 1'b0);
      load("lbu", 3'b100, 32'h80000003, 1'b0, 2, 32'h00000080, 1'b1, 1'b0);
      load("lh", 3'b001, 32'h80000002, 1'b0, 1, 32'hFFFF80FF, 1'b1, 1'b0);
      load("lhu", 3'b101, 32'h80000000, 1'b0, 0, 32'h00007F01, 1'b1, 1'b0);
      load("lw", 3'b010, 32'h80000004, 1'b0, 0, 32'h80FF7F01, 1'b1, 1'b0);
      chk("load_waddr", 32'(bus.rf_waddr), 32'd3);
      chk("load_cnt", bus.commit_cnt, 32'd6);
      issue(5'd0, 1'b1, 32'h12345678, 1'b0, 3'b000);
      chk("x0_done", 32'(bus.wb_done), 32'd1);
      chk("x0_wen", 32'(bus.rf_wen), 32'd0);
      chk("x0_err", 32'(bus.wb_err), 32'd0);
      step();
      issue(5'd17, 1'b1, 32'h12345678, 1'b0, 3'b000);
      chk("rd17_wen", 32'(bus.rf_wen), 32'd0);
      chk("rd17_err", 32'(bus.wb_err), 32'd1);
      step();
      chk("err_sticky", 32'(bus.wb_err), 32'd1);
      do_reset();
      load("resp_err", 3'b010, 32'h80000000, 1'b1, 0, 32'h0, 1'b0, 1'b1);
      do_reset();
      load("resp_wins", 3'b010, 32'h80000000, 1'b0, 3, 32'h80FF7F01, 1'b1, 1'b0);
      do_reset();
      issue(5'd3, 1'b1, 32'h80000002, 1'b1, 3'b010);
      chk("mis_done", 32'(bus.wb_done), 32'd1);
      chk("mis_wen", 32'(bus.rf_wen), 32'd0);
      chk("mis_err", 32'(bus.wb_err), 32'd1);
      do_reset();
      issue(5'd3, 1'b1, 32'h80000001, 1'b1, 3'b011);
      chk("badf3_done", 32'(bus.wb_done), 32'd1);
      chk("badf3_err", 32'(bus.wb_err), 32'd1);
      do_reset();
      issue(5'd3, 1'b1, 32'h80000000, 1'b1, 3'b010);
      repeat (3) step();
      chk("to_wait", 32'(bus.wb_done), 32'd0);
      step();
      chk("to_done", 32'(bus.wb_done), 32'd1);
      chk("to_wen", 32'(bus.rf_wen), 32'd0);
      chk("to_err", 32'(bus.wb_err), 32'd1);
      step();
      bus.rresp_valid = 1'b1;
      bus.rresp_data  = 32'h80FF7F01;
      step();
      bus.rresp_valid = 1'b0;
      chk("late_done", 32'(bus.wb_done), 32'd0);
      chk("late_wen", 32'(bus.rf_wen), 32'd0);
      chk("late_cnt", bus.commit_cnt, 32'd1);
      chk("late_ready", 32'(bus.in_ready), 32'd1);
      issue(5'd3, 1'b1, 32'h80000000, 1'b1, 3'b010);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_cnt", bus.commit_cnt, 32'd0);
      chk("mid_err", 32'(bus.wb_err), 32'd0);
      chk("mid_waddr", 32'(bus.rf_waddr), 32'd0);
      step();
      rst = 1'b1;
      bus.rresp_valid = 1'b1;
      step();
      bus.rresp_valid = 1'b0;
      chk("post_ready", 32'(bus.in_ready), 32'd1);
      chk("post_done", 32'(bus.wb_done), 32'd0);
      chk("post_cnt", bus.commit_cnt, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
